// File: rtl/data_mem_responder.sv
// Word-addressed data memory answering datapath loads/stores over a REQ/READY handshake
// with a fixed access latency. Define DMEM_ALIGN_CHECK_EN to flag misaligned addresses as errors.
module data_mem_responder #(
    parameter int unsigned DEPTH     = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned LATENCY   = 1
) (
    input  logic        clk,
    input  logic        reset,   // active low
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        err
);
    localparam int unsigned AW       = $clog2(DEPTH);
    localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);
`ifdef DMEM_ALIGN_CHECK_EN
    localparam bit ALIGN_CHECK = 1'b1;
`else
    localparam bit ALIGN_CHECK = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      state, state_next;
    logic [3:0]  cnt, cnt_next;
    logic        we_q;
    logic [31:0] addr_q, wdata_q;
    logic        accept, do_access;

    logic [29:0]   off_word;
    logic [AW-1:0] idx;
    logic          in_range, align_bad, access_err;

    logic [31:0] mem [DEPTH];

    // BASE_ADDR is word aligned, so subtracting word addresses equals off[31:2].
    always_comb begin
        off_word   = addr_q[31:2] - BASE_ADDR[31:2];
        idx        = off_word[AW-1:0];
        in_range   = {2'b00, off_word} < 32'(DEPTH);
        align_bad  = ALIGN_CHECK && (addr_q[1:0] != 2'b00);
        access_err = !in_range || align_bad;
    end

    // NOTE: every output of this block gets a default first, so no path leaves a latch.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        accept     = 1'b0;
        do_access  = 1'b0;
        ready      = 1'b0;
        unique case (state)
            IDLE: begin
                if (req) begin
                    accept     = 1'b1;
                    cnt_next   = CNT_INIT;
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (cnt != 4'd0) begin
                    cnt_next = cnt - 4'd1;
                end else begin
                    do_access  = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                ready      = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            rdata   <= 32'd0;
            err     <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (accept) begin
                we_q    <= we;
                addr_q  <= addr;
                wdata_q <= wdata;
            end
            if (do_access) begin
                err   <= access_err;
                rdata <= (!we_q && !access_err) ? mem[idx] : 32'd0;
            end
        end
    end

    // NOTE: the array is deliberately not reset; contents must survive reset, and an
    // aborted store never writes because reset forces IDLE before any access edge.
    always_ff @(posedge clk) begin
        if (do_access && we_q && !access_err) begin
            mem[idx] <= wdata_q;
        end
    end
endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized scoreboard bench for data_mem_responder: driver pushes model predictions,
// a negedge monitor pops them whenever READY is seen.
module tb_data_mem_responder;
    localparam int unsigned DEPTH     = 1024;
    localparam logic [31:0] BASE_ADDR = 32'h0000_0000;
    localparam int unsigned LATENCY   = 3;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic        req   = 1'b0;
    logic        we    = 1'b0;
    logic [31:0] addr  = 32'd0;
    logic [31:0] wdata = 32'd0;
    logic [31:0] rdata;
    logic        ready;
    logic        err;

    data_mem_responder #(
        .DEPTH    (DEPTH),
        .BASE_ADDR(BASE_ADDR),
        .LATENCY  (LATENCY)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .req  (req),
        .we   (we),
        .addr (addr),
        .wdata(wdata),
        .rdata(rdata),
        .ready(ready),
        .err  (err)
    );

    always #5 clk = ~clk;

    int cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    typedef struct {
        logic        err;
        logic [31:0] data;
        bit          dc;
        int          cyc;
        string       name;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] model_mem [int];
    int          checks      = 0;
    int          failures    = 0;
    int          ready_count = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: byte address -> word slot, range/alignment rules, plain array.
    function automatic exp_t model(input bit w, input logic [31:0] a, input logic [31:0] d,
                                   input int cyc, input string name);
        exp_t        e;
        logic [31:0] off;
        int unsigned word;
        bit          bad;
        off  = a - BASE_ADDR;
        word = off / 4;
        bad  = (word >= DEPTH);
`ifdef DMEM_ALIGN_CHECK_EN
        if (a % 4 != 0) bad = 1'b1;
`endif
        e.cyc  = cyc;
        e.name = name;
        e.dc   = 1'b0;
        e.data = 32'd0;
        e.err  = bad;
        if (!bad) begin
            if (w) model_mem[int'(word)] = d;
            else if (model_mem.exists(int'(word))) e.data = model_mem[int'(word)];
            else e.dc = 1'b1;
        end
        return e;
    endfunction

    always @(negedge clk) begin
        if (reset && ready === 1'b1) begin
            ready_count++;
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_ready: actual=READY at cycle %0d required=no READY", cycle);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check({e.name, "_cycle"}, 32'(cycle), 32'(e.cyc));
                check({e.name, "_err"}, 32'(err), 32'(e.err));
                if (!e.dc) check({e.name, "_rdata"}, rdata, e.data);
            end
        end
    end

    // Called at a negedge with the DUT idle; returns at the negedge of the following idle cycle.
    task automatic txn(input bit w, input logic [31:0] a, input logic [31:0] d,
                       input bit churn, input bit hold, input string name);
        bit seen;
        seen  = 1'b0;
        req   = 1'b1;
        we    = w;
        addr  = a;
        wdata = d;
        sb.push_back(model(w, a, d, cycle + 1 + int'(LATENCY), name));
        for (int i = 0; i < int'(LATENCY) + 10 && !seen; i++) begin
            @(negedge clk);
            if (ready === 1'b1) seen = 1'b1;
            if (churn) begin
                we    = 1'($urandom);
                addr  = $urandom;
                wdata = $urandom;
            end
        end
        if (!seen) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout: actual=no READY required=READY within %0d cycles", name, LATENCY + 10);
        end
        if (!hold) req = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual=still running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] a;
        int          kind;
        int          base_ready;
        bit          seen;

        #1 reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("rst_ready", 32'(ready), 32'd0);
            check("rst_err", 32'(err), 32'd0);
            check("rst_rdata", rdata, 32'd0);
        end
        reset = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("idle_ready", 32'(ready), 32'd0);
            check("idle_rdata", rdata, 32'd0);
        end

        for (int i = 0; i < 16; i++) txn(1'b1, 32'(i * 4), $urandom, 1'b0, 1'b0, "fill");
        txn(1'b1, 32'h0000_0FFC, $urandom, 1'b0, 1'b0, "fill_top");

        txn(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 1'b0, "st_deadbeef");
        txn(1'b0, 32'h0000_0010, 32'd0, 1'b0, 1'b0, "ld_deadbeef");

        // Load whose DONE cycle is cut short by an asynchronous reset between edges.
        req  = 1'b1;
        we   = 1'b0;
        addr = 32'h0000_0010;
        sb.push_back(model(1'b0, 32'h0000_0010, 32'd0, cycle + 1 + int'(LATENCY), "ld_async"));
        seen = 1'b0;
        for (int i = 0; i < int'(LATENCY) + 10 && !seen; i++) begin
            @(negedge clk);
            if (ready === 1'b1) seen = 1'b1;
        end
        req = 1'b0;
        #2 reset = 1'b0;
        #1;
        check("async_rst_ready", 32'(ready), 32'd0);
        check("async_rst_rdata", rdata, 32'd0);
        check("async_rst_err", 32'(err), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        txn(1'b1, 32'h0000_1000, 32'h1234_5678, 1'b0, 1'b0, "st_oob");
        txn(1'b0, 32'h0000_0000, 32'd0, 1'b0, 1'b0, "ld_word0");
        txn(1'b0, 32'h0000_0FFC, 32'd0, 1'b0, 1'b0, "ld_top");
        txn(1'b0, 32'hFFFF_FFFC, 32'd0, 1'b0, 1'b0, "ld_oob_high");

        txn(1'b1, 32'h0000_0006, 32'h1234_5678, 1'b0, 1'b0, "st_unaligned");
        txn(1'b0, 32'h0000_0004, 32'd0, 1'b0, 1'b0, "ld_word1");

        for (int i = 0; i < 12; i++)
            txn(1'($urandom), 32'($urandom_range(0, 15) * 4), $urandom, 1'b1, (i != 11), "b2b");

        // Store aborted by reset while BUSY: no READY, array untouched.
        base_ready = ready_count;
        req   = 1'b1;
        we    = 1'b1;
        addr  = 32'h0000_0020;
        wdata = 32'hCAFE_F00D;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        req   = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (LATENCY + 4) @(negedge clk);
        check("abort_no_ready", 32'(ready_count - base_ready), 32'd0);
        txn(1'b0, 32'h0000_0020, 32'd0, 1'b0, 1'b0, "ld_after_abort");

        for (int i = 0; i < 40; i++) begin
            kind = $urandom_range(0, 9);
            if (kind == 0) a = {20'($urandom_range(1, 20'hFFFFF)), 10'($urandom), 2'($urandom)};
            else if (kind == 1) a = 32'($urandom_range(0, 15) * 4 + $urandom_range(1, 3));
            else a = 32'($urandom_range(0, 15) * 4);
            txn(1'($urandom), a, $urandom, 1'($urandom), 1'($urandom), "rand");
        end

        repeat (LATENCY + 4) @(negedge clk);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Word-addressed data memory that answers the load/store requests issued by the processor datapath's memory port. It sits on the far side of the datapath's address, write-data and read-data lines, and adds a REQ/READY handshake with a configurable access latency, so the core can be moved off an ideal combinational memory. Out-of-range accesses are flagged rather than silently aliased.

## Interface
- DEPTH, 1024, number of 32-bit words in the array (power of two, ≥ 2)
- BASE_ADDR, 32'h0000_0000, byte address mapped to word 0 (word-aligned)
- LATENCY, 1, edges from acceptance to access (1..15)
- CLK  in  1  clock; all state changes on rising edge
- RESET  in  1  asynchronous, active-low reset (0 = reset asserted)
- REQ  in  1  request valid; sampled only in IDLE
- WE  in  1  1 = store, 0 = load; latched on acceptance
- ADDR  in  32  byte address; latched on acceptance
- WDATA  in  32  store data; latched on acceptance
- RDATA  out  32  load data; valid only while READY = 1
- READY  out  1  one-cycle completion pulse
- ERR  out  1  error flag; valid only while READY = 1

## Operation
- Index: off = ADDR_q − BASE_ADDR (32-bit wrapping subtract); word index = off[31:2]; in range iff off[31:2] < DEPTH.
- FSM states: IDLE, BUSY, DONE. Counter cnt is 4 bits.
- IDLE: READY = 0. If REQ = 1, latch WE/ADDR/WDATA, cnt ← LATENCY−1, go BUSY. Otherwise stay.
- BUSY: if cnt ≠ 0, cnt ← cnt−1. If cnt = 0, perform the access and go DONE:
  - For an in-range store, write WDATA_q into the array. RDATA ← 0 and ERR ← 0.
  - For an in-range load, RDATA ← array[index] and ERR ← 0.
  - For an error, the array is unchanged, RDATA ← 0 and ERR ← 1.
- DONE: READY = 1, ERR and RDATA are held, then go IDLE unconditionally.
- REQ and input changes during BUSY and DONE are ignored. The latched copies are used.
- The requester holds REQ until it sees READY. If REQ is still high in the cycle after DONE, this is a new request, and it is accepted at the next edge from IDLE.
- Storage has no reset. Array contents survive RESET.

## Timing
- Reset values: state = IDLE, READY = 0, ERR = 0, RDATA = 0, cnt = 0. These take effect immediately when RESET falls, without waiting for CLK.
- Reset during BUSY or DONE aborts the transaction. A pending store is dropped and the array is not written.
- Acceptance at edge t, access at edge t+LATENCY. READY is high from edge t+LATENCY to edge t+LATENCY+1.
- Requests are accepted at most once every LATENCY+2 cycles: one IDLE cycle, LATENCY BUSY cycles, one DONE cycle.
- Reads are synchronous. RDATA is registered and contains no combinational path from ADDR.
- Store visibility: a load accepted after a store's READY returns the new data.

## Configuration
- DMEM_ALIGN_CHECK_EN defined: ADDR_q[1:0] ≠ 0 is an error. ERR = 1, no write, RDATA = 0.
- DMEM_ALIGN_CHECK_EN undefined: ADDR_q[1:0] is ignored. Accesses go to the containing word, and only the range check can raise ERR.

## Test plan
- Reset and idle, LATENCY = 1: hold RESET = 0 for 3 cycles, then release with REQ = 0. READY = 0, ERR = 0 and RDATA = 0 throughout. Asserting RESET between edges zeroes the outputs immediately.
- Store then load, LATENCY = 3: store 32'hDEAD_BEEF to 32'h0000_0010, accepted at edge t, with READY high in cycle t+3 and ERR = 0. Then load 32'h10. RDATA = 32'hDEAD_BEEF during its READY cycle.
- Range check, DEPTH = 1024, BASE_ADDR = 0: store 32'h1234_5678 to 32'h0000_1000. READY comes with ERR = 1. A load from 32'h0000_0000 still returns its prior value, and a load from 32'h0000_0FFC completes with ERR = 0.
- Alignment: store to 32'h0000_0006. With DMEM_ALIGN_CHECK_EN, ERR = 1 and word 1 is unchanged. Without it, ERR = 0 and word 1 = 32'h1234_5678.
- Back-to-back with input churn, LATENCY = 2: hold REQ = 1 continuously and change ADDR and WDATA every cycle while BUSY. Exactly one READY every 4 cycles, and each transaction uses the values latched at its acceptance edge.
- Reset mid-store, LATENCY = 4: accept a store of 32'hCAFE_F00D to 32'h20, then assert RESET one cycle later. No READY pulse occurs, and a later load from 32'h20 returns the pre-store value.
